pix_lane_gen: RTL
=================

// Module: pix_lane_gen
// PURPOSE
// - Multi-lane pixel coordinate generator for the work dispatcher; successor to the single-pixel x/y counter.
// - Each accepted beat hands up to LANES horizontally adjacent pixels (x_base..x_base+LANES-1, row y_value) to the compute lanes.
// - Raster order, row 0 first; valid/ready output handshake; frame bounds latched at start; done flag at frame end.
// PARAMETERS
// - CNT_BITS  10  width of x/y coordinates and bounds (max 2^CNT_BITS-1)
// - LANES     4   pixels per beat, integer >= 1 (not required to be a power of 2)
// PORTS
// - clk        in   1         system clock, rising edge
// - n_rst      in   1         asynchronous active-low reset
// - start      in   1         begin frame; latches x_max/y_max
// - clear      in   1         synchronous abort to IDLE
// - x_max      in   CNT_BITS  last column index (inclusive)
// - y_max      in   CNT_BITS  last row index (inclusive)
// - out_ready  in   1         downstream accepts the current beat
// - out_valid  out  1         beat present
// - x_base     out  CNT_BITS  column of lane 0
// - y_value    out  CNT_BITS  row of the beat
// - lane_mask  out  LANES     bit i set: pixel x_base+i is inside the frame
// - last       out  1         final beat of the frame
// - busy       out  1         state == RUN
// - done       out  1         frame complete; held until start or clear
// BEHAVIOUR
// - Reset (n_rst=0, async): state IDLE; all outputs 0; latched bounds 0.
// - States: IDLE, RUN, DONE. busy = (RUN). out_valid = (RUN). done = (DONE).
// - IDLE/DONE + start: latch x_max/y_max, x_base=0, y_value=0, enter RUN next edge; done drops same edge.
// - start while in RUN: ignored; latched bounds unchanged.
// - clear: highest priority, every state; next edge -> IDLE, all outputs 0. clear+start same cycle: clear wins.
// - Transfer = out_valid & out_ready. No transfer: x_base, y_value, lane_mask, last held stable.
// - lane_mask[i] = (x_base + i <= x_max_l), sum formed at CNT_BITS+1 bits (no wrap at 2^CNT_BITS-1).
// - row_end = (x_base + LANES > x_max_l), CNT_BITS+1-bit compare. last = row_end & (y_value == y_max_l).
// - On transfer, not row_end: x_base += LANES.
// - On transfer, row_end, not last: x_base = 0, y_value += 1.
// - On transfer with last: -> DONE next edge; out_valid, lane_mask, last go 0; x_base, y_value reset to 0.
// - Latency: first beat valid 1 cycle after start sampled; one beat per cycle at out_ready=1 with no bubbles.
// - Beats per frame = (y_max+1) * ceil((x_max+1)/LANES); lane_mask all-ones except the final beat of each row.
// - x_max=0, y_max=0: one beat, lane_mask = 1 in bit 0 only, last=1.
// - Bounds inputs only sampled on accepted start; changes during RUN have no effect.
// - Reset mid-frame: immediate IDLE, outputs 0; no beat resumed.
// TESTING
// - Reset asserted mid-RUN -> out_valid, busy, done, x_base, y_value, lane_mask, last all 0 immediately (async).
// - LANES=4, x_max=9, y_max=1, out_ready=1, start pulse -> 6 beats (x_base,y): (0,0)(4,0)(8,0)(0,1)(4,1)(8,1); masks 1111,1111,0011 per row; last only on beat 6; done=1 next cycle, held.
// - Same frame, out_ready toggled 1,0,0,1,... -> outputs frozen during stalls; identical 6-beat sequence; start pulsed mid-frame ignored.
// - x_max=0, y_max=0 -> single beat x_base=0, y=0, lane_mask=0001, last=1, then done=1.
// - CNT_BITS=10, x_max=1023, y_max=0 -> 256 beats; beat x_base=1020 mask 1111, last=1; no x wrap to 0 before it.
// - clear at beat 3 of x_max=9, y_max=1 frame -> IDLE, outputs 0; clear+start same cycle -> stays IDLE; later start -> full 6-beat frame from (0,0).

Source files
------------

// File: rtl/pix_lane_gen.sv
// Multi-lane raster pixel coordinate generator: each accepted beat carries LANES
// horizontally adjacent pixels (x_base..x_base+LANES-1) of row y_value.
module pix_lane_gen #(
    parameter int CNT_BITS = 10,
    parameter int LANES    = 4
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                start,
    input  logic                clear,
    input  logic [CNT_BITS-1:0] x_max,
    input  logic [CNT_BITS-1:0] y_max,
    input  logic                out_ready,
    output logic                out_valid,
    output logic [CNT_BITS-1:0] x_base,
    output logic [CNT_BITS-1:0] y_value,
    output logic [LANES-1:0]    lane_mask,
    output logic                last,
    output logic                busy,
    output logic                done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // One extra bit so x_base + offset never wraps when the frame spans 2^CNT_BITS columns.
    localparam int              SW      = CNT_BITS + 1;
    localparam logic [SW-1:0]   LANES_W = SW'(LANES);

    state_t                state_q,   state_d;
    logic [CNT_BITS-1:0]   x_base_q,  x_base_d;
    logic [CNT_BITS-1:0]   y_value_q, y_value_d;
    logic [CNT_BITS-1:0]   x_max_q,   x_max_d;
    logic [CNT_BITS-1:0]   y_max_q,   y_max_d;
    logic [LANES-1:0]      lane_mask_q, lane_mask_d;
    logic                  last_q,    last_d;
    logic                  valid_q,   valid_d;
    logic                  busy_q,    busy_d;
    logic                  done_q,    done_d;

    logic                  xfer;
    logic                  row_end;
    logic                  frame_end;

    assign xfer      = (state_q == ST_RUN) && out_ready;
    assign row_end   = (({1'b0, x_base_q} + LANES_W) > {1'b0, x_max_q});
    assign frame_end = row_end && (y_value_q == y_max_q);

    always_comb begin
        state_d   = state_q;
        x_base_d  = x_base_q;
        y_value_d = y_value_q;
        x_max_d   = x_max_q;
        y_max_d   = y_max_q;
        if (clear) begin
            state_d   = ST_IDLE;
            x_base_d  = '0;
            y_value_d = '0;
            x_max_d   = '0;
            y_max_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_d   = ST_RUN;
                        x_base_d  = '0;
                        y_value_d = '0;
                        x_max_d   = x_max;
                        y_max_d   = y_max;
                    end
                end
                ST_RUN: begin
                    if (xfer) begin
                        if (frame_end) begin
                            state_d   = ST_DONE;
                            x_base_d  = '0;
                            y_value_d = '0;
                        end else if (row_end) begin
                            x_base_d  = '0;
                            y_value_d = y_value_q + CNT_BITS'(1);
                        end else begin
                            x_base_d  = x_base_q + CNT_BITS'(LANES);
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Beat qualifiers are computed from the next coordinates so they register alongside them.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign lane_mask_d[gi] = (state_d == ST_RUN) &&
                                     (({1'b0, x_base_d} + SW'(gi)) <= {1'b0, x_max_d});
        end
    endgenerate

    assign last_d  = (state_d == ST_RUN) &&
                     (({1'b0, x_base_d} + LANES_W) > {1'b0, x_max_d}) &&
                     (y_value_d == y_max_d);
    assign valid_d = (state_d == ST_RUN);
    assign busy_d  = (state_d == ST_RUN);
    assign done_d  = (state_d == ST_DONE);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= ST_IDLE;
            x_base_q    <= '0;
            y_value_q   <= '0;
            x_max_q     <= '0;
            y_max_q     <= '0;
            lane_mask_q <= '0;
            last_q      <= 1'b0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_base_q    <= x_base_d;
            y_value_q   <= y_value_d;
            x_max_q     <= x_max_d;
            y_max_q     <= y_max_d;
            lane_mask_q <= lane_mask_d;
            last_q      <= last_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign out_valid = valid_q;
    assign x_base    = x_base_q;
    assign y_value   = y_value_q;
    assign lane_mask = lane_mask_q;
    assign last      = last_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
